n64_ctrl_sniffer_mp: RTL and testbench



---
 rtl/n64_ctrl_pkg.sv | 19 +
 rtl/n64_ctrl_port_rx.sv | 130 +++++++++++++
 rtl/n64_ctrl_sniffer_mp.sv | 187 ++++++++++++++++++
 tb/tb_n64_ctrl_sniffer_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_ctrl_pkg.sv
// Shared definitions for the multi-port N64 controller-bus sniffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package n64_ctrl_pkg;

  // Per-port joybus decoder state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // Console poll command; only its responses are captured
  localparam logic [7:0] JOY_CMD_POLL = 8'h01;

  // Width of the source-port index carried with each frame
  localparam int PORT_W = 2;

endpackage

// File: rtl/n64_ctrl_port_rx.sv
// Single-line joybus decoder: sync, edge detect, interval timing, poll-response capture.
// Latency: edges seen 3 cycles after the line; o_latch is combinational on the closing falling edge.
// Backpressure: none; the line is sniffed passively, the parent buffers each frame.
module n64_ctrl_port_rx
  import n64_ctrl_pkg::*;
#(
  parameter int WAIT_W    = 8,
  parameter int RESP_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_line,
  output logic                 o_latch,
  output logic [RESP_BITS-1:0] o_data,
  output logic                 o_detected
);

  localparam int                CNT_W     = $clog2(RESP_BITS + 1);
  localparam logic [WAIT_W-1:0] SAT       = '1;
  localparam logic [CNT_W-1:0]  CMD_BITS  = CNT_W'(8);
  localparam logic [CNT_W-1:0]  RESP_LAST = CNT_W'(RESP_BITS - 1);

  logic [1:0]           r_sync;
  logic                 r_hist;
  logic [WAIT_W-1:0]    r_cnt;
  logic [WAIT_W-1:0]    r_low_cnt;
  port_state_e          r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [RESP_BITS-1:0] r_shift;
  logic                 r_det;

  logic                 w_fall;
  logic                 w_rise;
  logic                 w_sat;
  logic                 w_bit;
  logic [RESP_BITS-1:0] w_resp_shift;

  assign w_fall = r_hist & ~r_sync[1];
  assign w_rise = ~r_hist & r_sync[1];
  assign w_sat  = (r_cnt == SAT);
  // A bit is 1 when its high phase outlasts its low phase
  assign w_bit  = (r_low_cnt < r_cnt);
  // Response bits arrive LSB first, so shift in from the top
  assign w_resp_shift = {w_bit, r_shift[RESP_BITS-1:1]};

  assign o_latch    = (r_state == ST_RESP) && w_fall && !w_sat && (r_bit_cnt == RESP_LAST);
  assign o_data     = w_resp_shift;
  assign o_detected = r_det;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_hist <= r_sync[1];
    end
  end

  // Interval counter: restarts on every edge, sticks at all-ones when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_fall || w_rise) begin
      r_cnt <= '0;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + WAIT_W'(1);
    end
  end

  // Frame decoder: command byte MSB first, then the poll response LSB first
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_low_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_det     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall && w_sat) begin
            r_state   <= ST_CMD;
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
        end
        default: begin
          if (w_sat) begin
            // Line went quiet mid-frame; a silent poll means no controller
            if (r_state == ST_CMD) r_det <= 1'b0;
            if (w_fall) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_rise) begin
            r_low_cnt <= r_cnt;
          end else if (w_fall) begin
            if (r_state == ST_CMD) begin
              if (r_bit_cnt == CMD_BITS) begin
                if (r_shift[7:0] == JOY_CMD_POLL) begin
                  r_state   <= ST_RESP;
                  r_bit_cnt <= '0;
                end else begin
                  r_state <= ST_IDLE;
                end
              end else begin
                r_shift   <= {r_shift[RESP_BITS-2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end else begin
              r_shift <= w_resp_shift;
              if (r_bit_cnt == RESP_LAST) begin
                r_det   <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/n64_ctrl_sniffer_mp.sv
// Multi-port joybus sniffer: per-port poll-response capture, round-robin frame output, optional IGR reset (N64_CTRL_IGR_EN).
// Latency: frame_valid_o rises on the edge that latches the frame when the output is free.
// Backpressure: valid/ready; one frame buffered per port, a newer frame overwrites and flags ovr.
module n64_ctrl_sniffer_mp
  import n64_ctrl_pkg::*;
#(
  parameter int          NUM_PORTS = 1,
  parameter int          WAIT_W    = 8,
  parameter int          RESP_BITS = 32,
  parameter logic [15:0] IGR_COMBO = 16'h0000,
  parameter logic [19:0] RST_LEN   = 20'hFFFFF
) (
  input  logic                 CTRL_CLK,
  input  logic                 CTRL_RST,
  input  logic [NUM_PORTS-1:0] CTRL_i,
  output logic [RESP_BITS-1:0] frame_data_o,
  output logic [PORT_W-1:0]    frame_port_o,
  output logic                 frame_ovr_o,
  output logic                 frame_valid_o,
  input  logic                 frame_ready_i,
  output logic [NUM_PORTS-1:0] ctrl_detected_o,
  input  logic                 igr_en_i,
  output logic                 n64_rst_drv_o
);

  logic [NUM_PORTS-1:0] w_latch;
  logic [RESP_BITS-1:0] w_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_det;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      n64_ctrl_port_rx #(
        .WAIT_W    (WAIT_W),
        .RESP_BITS (RESP_BITS)
      ) u_rx (
        .i_clk      (CTRL_CLK),
        .i_rst      (CTRL_RST),
        .i_line     (CTRL_i[g]),
        .o_latch    (w_latch[g]),
        .o_data     (w_data[g]),
        .o_detected (w_det[g])
      );
    end
  endgenerate

  assign ctrl_detected_o = w_det;

  logic [NUM_PORTS-1:0] r_pend;
  logic [NUM_PORTS-1:0] r_povr;
  logic [RESP_BITS-1:0] r_buf [NUM_PORTS];
  logic                 r_vld;
  logic [RESP_BITS-1:0] r_dat;
  logic [PORT_W-1:0]    r_port;
  logic                 r_ovr;

  logic                 w_hs;
  logic [NUM_PORTS-1:0] w_take;
  logic [NUM_PORTS-1:0] w_pend_nx;
  logic [NUM_PORTS-1:0] w_povr_nx;
  logic [RESP_BITS-1:0] w_buf_nx [NUM_PORTS];
  logic                 w_sel_ok;
  logic [PORT_W-1:0]    w_sel;
  logic [RESP_BITS-1:0] w_sel_dat;
  logic                 w_sel_ovr;
  logic                 w_cur_latch;
  logic [RESP_BITS-1:0] w_cur_dat;
  int                   w_dist;
  int                   w_best;

  assign w_hs          = r_vld & frame_ready_i;
  assign frame_valid_o = r_vld;
  assign frame_data_o  = r_dat;
  assign frame_port_o  = r_port;
  assign frame_ovr_o   = r_ovr;

  // Next buffer state: a latch beats a same-cycle handshake, ovr only if the old frame was unread
  always_comb begin
    w_take    = '0;
    w_pend_nx = '0;
    w_povr_nx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_take[p]    = w_hs && (r_port == PORT_W'(p));
      w_pend_nx[p] = w_latch[p] | (r_pend[p] & ~w_take[p]);
      w_povr_nx[p] = w_latch[p] ? (r_pend[p] & ~w_take[p]) : (r_povr[p] & ~w_take[p]);
      w_buf_nx[p]  = w_latch[p] ? w_data[p] : r_buf[p];
    end
  end

  // Round-robin pick: lowest distance after the last granted port wins
  always_comb begin
    w_sel_ok    = 1'b0;
    w_sel       = '0;
    w_sel_dat   = '0;
    w_sel_ovr   = 1'b0;
    w_cur_latch = 1'b0;
    w_cur_dat   = '0;
    w_dist      = 0;
    w_best      = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_dist = p - int'(r_port) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_PORTS;
      if (w_pend_nx[p] && (!w_sel_ok || (w_dist < w_best))) begin
        w_sel_ok  = 1'b1;
        w_best    = w_dist;
        w_sel     = PORT_W'(p);
        w_sel_dat = w_buf_nx[p];
        w_sel_ovr = w_povr_nx[p];
      end
      if (r_port == PORT_W'(p)) begin
        w_cur_latch = w_latch[p];
        w_cur_dat   = w_data[p];
      end
    end
  end

  // Per-port single-frame buffers
  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      r_pend <= '0;
      r_povr <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_buf[p] <= '0;
    end else begin
      r_pend <= w_pend_nx;
      r_povr <= w_povr_nx;
      for (int p = 0; p < NUM_PORTS; p++) r_buf[p] <= w_buf_nx[p];
    end
  end

  // Output register: regrant when free, otherwise hold; an overwrite of the
  // offered port is folded in so the newer frame is not dropped at handshake
  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_port <= '0;
      r_ovr  <= 1'b0;
    end else if (!r_vld || w_hs) begin
      r_vld <= w_sel_ok;
      if (w_sel_ok) begin
        r_port <= w_sel;
        r_dat  <= w_sel_dat;
        r_ovr  <= w_sel_ovr;
      end
    end else if (w_cur_latch) begin
      r_dat <= w_cur_dat;
      r_ovr <= 1'b1;
    end
  end

`ifdef N64_CTRL_IGR_EN
  logic [19:0] r_rst_cnt;
  logic        r_rst_drv;
  logic        w_igr_hit;

  assign n64_rst_drv_o = r_rst_drv;

  // Any port latching the combo while enabled triggers the reset pulse
  always_comb begin
    w_igr_hit = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_latch[p] && (16'(w_data[p]) == IGR_COMBO)) w_igr_hit = 1'b1;
    end
    w_igr_hit = w_igr_hit & igr_en_i;
  end

  // Reset pulse timer: reload on every match, release once drained
  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      r_rst_cnt <= '0;
      r_rst_drv <= 1'b0;
    end else if (w_igr_hit) begin
      r_rst_cnt <= RST_LEN;
      r_rst_drv <= 1'b1;
    end else if (r_rst_cnt != 20'd0) begin
      r_rst_cnt <= r_rst_cnt - 20'd1;
    end else begin
      r_rst_drv <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_unused      = ^{igr_en_i, IGR_COMBO, RST_LEN};
  assign n64_rst_drv_o = 1'b0;
`endif

endmodule

// File: tb/tb_n64_ctrl_sniffer_mp.sv
// Directed bench for the multi-port joybus sniffer: table of transactions plus corner sequences.
// Latency: n/a.
// Backpressure: frame_ready_i driven by the bench.
module tb_n64_ctrl_sniffer_mp;

  localparam int NP = 4;
  localparam int RB = 32;

`ifdef N64_CTRL_IGR_EN
  localparam int IGR_EXP = 101;
`else
  localparam int IGR_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] line;
  logic          ready;
  logic          igr_en;
  logic [RB-1:0] frame_data;
  logic [1:0]    frame_port;
  logic          frame_ovr;
  logic          frame_valid;
  logic [NP-1:0] det;
  logic          rst_drv;

  int checks   = 0;
  int failures = 0;
  int drv_cycles = 0;

  always #5 clk = ~clk;

  n64_ctrl_sniffer_mp #(
    .NUM_PORTS (NP),
    .WAIT_W    (8),
    .RESP_BITS (RB),
    .IGR_COMBO (16'h0F00),
    .RST_LEN   (20'd100)
  ) u_dut (
    .CTRL_CLK        (clk),
    .CTRL_RST        (rst),
    .CTRL_i          (line),
    .frame_data_o    (frame_data),
    .frame_port_o    (frame_port),
    .frame_ovr_o     (frame_ovr),
    .frame_valid_o   (frame_valid),
    .frame_ready_i   (ready),
    .ctrl_detected_o (det),
    .igr_en_i        (igr_en),
    .n64_rst_drv_o   (rst_drv)
  );

  always @(negedge clk) if (rst_drv) drv_cycles <= drv_cycles + 1;

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  cmd;
    logic [31:0] resp;
    logic        exp_vld;
    logic [31:0] exp_dat;
    logic [1:0]  exp_port;
    logic [3:0]  exp_det;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Hold the masked lines low (lvl=0) or all lines high for n cycles
  task automatic hold(input logic lvl, input logic [3:0] mask, input int n);
    line = lvl ? 4'hF : ~mask;
    repeat (n) @(negedge clk);
  endtask

  // 1: 1 us low / 3 us high; 0: 3 us low / 1 us high (4 cycles per us)
  task automatic send_bit(input logic [3:0] mask, input logic b);
    if (b) begin
      hold(1'b0, mask, 4);
      hold(1'b1, mask, 12);
    end else begin
      hold(1'b0, mask, 12);
      hold(1'b1, mask, 4);
    end
  endtask

  // Idle, command byte MSB first, console stop, then nresp response bits LSB first
  task automatic tx(input logic [3:0] mask, input logic [7:0] cmd, input int nresp,
                    input logic [31:0] resp);
    hold(1'b1, mask, 300);
    for (int i = 7; i >= 0; i--) send_bit(mask, cmd[i]);
    hold(1'b0, mask, 4);
    hold(1'b1, mask, 8);
    for (int i = 0; i < nresp; i++) send_bit(mask, resp[i]);
    if (nresp == 32) begin
      hold(1'b0, mask, 8);
      hold(1'b1, mask, 4);
    end
  endtask

  task automatic consume(input string name);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({name, "_drain"}, {31'd0, frame_valid}, 32'd0);
  endtask

  initial begin
    int bad;
    int base;

    vt[0] = '{4'b0001, 8'h01, 32'h0000_0010, 1'b1, 32'h0000_0010, 2'd0, 4'b0001};
    vt[1] = '{4'b0001, 8'h00, 32'hDEAD_BEEF, 1'b0, 32'h0,         2'd0, 4'b0001};
    vt[2] = '{4'b0100, 8'h01, 32'h1234_5678, 1'b1, 32'h1234_5678, 2'd2, 4'b0101};
    vt[3] = '{4'b0010, 8'h01, 32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F, 2'd1, 4'b0111};
    vt[4] = '{4'b1000, 8'h02, 32'hFFFF_0000, 1'b0, 32'h0,         2'd0, 4'b0111};
    vt[5] = '{4'b1000, 8'h01, 32'h8000_0001, 1'b1, 32'h8000_0001, 2'd3, 4'b1111};

    rst    = 1'b1;
    line   = 4'hF;
    ready  = 1'b0;
    igr_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_data",  frame_data, 32'd0);
    chk("rst_port",  {30'd0, frame_port}, 32'd0);
    chk("rst_ovr",   {31'd0, frame_ovr}, 32'd0);
    chk("rst_det",   {28'd0, det}, 32'd0);
    chk("rst_drv",   {31'd0, rst_drv}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      tx(vt[v].mask, vt[v].cmd, 32, vt[v].resp);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_valid", v), {31'd0, frame_valid}, {31'd0, vt[v].exp_vld});
      if (vt[v].exp_vld) begin
        chk($sformatf("v%0d_data", v), frame_data, vt[v].exp_dat);
        chk($sformatf("v%0d_port", v), {30'd0, frame_port}, {30'd0, vt[v].exp_port});
        chk($sformatf("v%0d_ovr", v),  {31'd0, frame_ovr}, 32'd0);
      end
      chk($sformatf("v%0d_det", v), {28'd0, det}, {28'd0, vt[v].exp_det});
      if (vt[v].exp_vld) consume($sformatf("v%0d", v));
    end

    // Poll with no answer: detected drops, then the port still decodes
    tx(4'b0001, 8'h01, 0, 32'h0);
    hold(1'b1, 4'b0001, 300);
    chk("noresp_det",   {28'd0, det}, {28'd0, 4'b1110});
    chk("noresp_valid", {31'd0, frame_valid}, 32'd0);
    tx(4'b0001, 8'h01, 32, 32'h0000_00FF);
    repeat (2) @(negedge clk);
    chk("recov_data", frame_data, 32'h0000_00FF);
    chk("recov_det",  {28'd0, det}, {28'd0, 4'b1111});
    consume("recov");

    // Ports 1 and 3 latch together; grant held stable, then back-to-back
    tx(4'b1010, 8'h01, 32, 32'h0000_5555);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (frame_valid !== 1'b1 || frame_port !== 2'd1 || frame_data !== 32'h0000_5555) bad++;
      @(negedge clk);
    end
    chk("rr_hold_stable", bad, 0);
    chk("rr_first_port", {30'd0, frame_port}, 32'd1);
    chk("rr_first_ovr",  {31'd0, frame_ovr}, 32'd0);
    ready = 1'b1;
    @(negedge clk);
    chk("rr_second_valid", {31'd0, frame_valid}, 32'd1);
    chk("rr_second_port",  {30'd0, frame_port}, 32'd3);
    chk("rr_second_data",  frame_data, 32'h0000_5555);
    @(negedge clk);
    ready = 1'b0;
    chk("rr_empty", {31'd0, frame_valid}, 32'd0);

    // Two frames on port 2 without reading: newest data, ovr set
    tx(4'b0100, 8'h01, 32, 32'h1111_2222);
    repeat (2) @(negedge clk);
    chk("ovr_first_data", frame_data, 32'h1111_2222);
    chk("ovr_first_ovr",  {31'd0, frame_ovr}, 32'd0);
    tx(4'b0100, 8'h01, 32, 32'h3333_4444);
    repeat (2) @(negedge clk);
    chk("ovr_second_data",  frame_data, 32'h3333_4444);
    chk("ovr_second_port",  {30'd0, frame_port}, 32'd2);
    chk("ovr_second_ovr",   {31'd0, frame_ovr}, 32'd1);
    consume("ovr");

    // Reset in the middle of a response with a frame still offered
    tx(4'b0010, 8'h01, 32, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    chk("mid_pre_valid", {31'd0, frame_valid}, 32'd1);
    tx(4'b0001, 8'h01, 10, 32'h0000_03FF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("mid_rst_data",  frame_data, 32'd0);
    chk("mid_rst_port",  {30'd0, frame_port}, 32'd0);
    chk("mid_rst_ovr",   {31'd0, frame_ovr}, 32'd0);
    chk("mid_rst_det",   {28'd0, det}, 32'd0);
    chk("mid_rst_drv",   {31'd0, rst_drv}, 32'd0);
    tx(4'b0001, 8'h01, 32, 32'h0BAD_BEEF);
    repeat (2) @(negedge clk);
    chk("post_rst_data", frame_data, 32'h0BAD_BEEF);
    chk("post_rst_port", {30'd0, frame_port}, 32'd0);
    chk("post_rst_det",  {28'd0, det}, {28'd0, 4'b0001});
    consume("post_rst");

    // In-game reset combo with and without enable
    igr_en = 1'b1;
    base = drv_cycles;
    tx(4'b0001, 8'h01, 32, 32'hABCD_0F00);
    hold(1'b1, 4'b0001, 200);
    chk("igr_on_cycles", drv_cycles - base, IGR_EXP);
    chk("igr_on_data", frame_data, 32'hABCD_0F00);
    consume("igr_on");
    igr_en = 1'b0;
    base = drv_cycles;
    tx(4'b0001, 8'h01, 32, 32'hABCD_0F00);
    hold(1'b1, 4'b0001, 200);
    chk("igr_off_cycles", drv_cycles - base, 0);
    consume("igr_off");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
